// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with valid/ready handshake, one-entry skid buffer, flush and freeze.
// Optional saturating stall counter enabled by defining PIPE_STALL_CNT_EN.
module exe_mem_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 3
`ifdef PIPE_STALL_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] alu_res_in,
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [DEST_W-1:0] dest_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] alu_res_out,
  output logic [DATA_W-1:0] val_rm_out,
  output logic [DEST_W-1:0] dest_out
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              push, pop;
  logic              load_main_in, load_main_skid, load_skid;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_alu,  skid_alu;
  logic [DATA_W-1:0] main_rm,   skid_rm;
  logic [DEST_W-1:0] main_dest, skid_dest;

  // Handshake is a pure function of state and the freeze/flush inputs.
  assign in_ready  = ~freeze & ~flush & (state != FULL);
  assign out_valid = (state != EMPTY) & ~freeze;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Freeze needs no explicit branch: it forces push and pop low.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin
          state_nxt    = ONE;
          load_main_in = 1'b1;
        end
        ONE: begin
          if (push && pop) begin
            load_main_in = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (pop) begin
          state_nxt      = ONE;
          load_main_skid = 1'b1;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_alu  <= '0;
      main_rm   <= '0;
      main_dest <= '0;
      skid_ctrl <= '0;
      skid_alu  <= '0;
      skid_rm   <= '0;
      skid_dest <= '0;
    end else begin
      if (load_main_in) begin
        main_ctrl <= ctrl_in;
        main_alu  <= alu_res_in;
        main_rm   <= val_rm_in;
        main_dest <= dest_in;
      end else if (load_main_skid) begin
        main_ctrl <= skid_ctrl;
        main_alu  <= skid_alu;
        main_rm   <= skid_rm;
        main_dest <= skid_dest;
      end
      if (load_skid) begin
        skid_ctrl <= ctrl_in;
        skid_alu  <= alu_res_in;
        skid_rm   <= val_rm_in;
        skid_dest <= dest_in;
      end
    end
  end

  // A bubble must never write back or touch memory.
  assign ctrl_out    = main_ctrl & {CTRL_W{out_valid}};
  assign alu_res_out = main_alu;
  assign val_rm_out  = main_rm;
  assign dest_out    = main_dest;

`ifdef PIPE_STALL_CNT_EN
  // Cleared only by reset; flush leaves the history intact.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// Directed bench for exe_mem_skid_reg: vector table plus reset and stall-counter sequences.
// Define PIPE_STALL_CNT_EN to also exercise the stall counter with CNT_W=4.
module tb_exe_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst, freeze, flush, in_valid, in_ready, out_valid, out_ready;
  logic [2:0]  ctrl_in, ctrl_out;
  logic [31:0] alu_res_in, val_rm_in, alu_res_out, val_rm_out;
  logic [3:0]  dest_in, dest_out;
`ifdef PIPE_STALL_CNT_EN
  logic [3:0]  stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef PIPE_STALL_CNT_EN
  exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3), .CNT_W(4)) dut (
`else
  exe_mem_skid_reg #(.DATA_W(32), .DEST_W(4), .CTRL_W(3)) dut (
`endif
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .ctrl_in(ctrl_in),
    .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
    .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out),
    .alu_res_out(alu_res_out), .val_rm_out(val_rm_out), .dest_out(dest_out)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct {
    logic        fz, fl, iv, ordy;
    logic [2:0]  ctrl;
    logic [31:0] alu;
    logic        e_ov, e_ir;
    logic [2:0]  e_ctrl;
    logic [31:0] e_alu;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Store data and destination are derived from the ALU value so one field carries the entry.
  task automatic drive(input logic fz, input logic fl, input logic iv, input logic ordy,
                       input logic [2:0] c, input logic [31:0] a);
    freeze     = fz;
    flush      = fl;
    in_valid   = iv;
    out_ready  = ordy;
    ctrl_in    = c;
    alu_res_in = a;
    val_rm_in  = ~a;
    dest_in    = a[3:0];
  endtask

  task automatic check_out(input string tag, input logic e_ov, input logic e_ir,
                           input logic [2:0] e_ctrl, input logic [31:0] e_alu);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
    check({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
    check({tag, ".ctrl_out"},  32'(ctrl_out),  32'(e_ctrl));
    check({tag, ".alu_res"},   alu_res_out,    e_alu);
    check({tag, ".val_rm"},    val_rm_out,     (e_alu == 32'h0) ? 32'h0 : ~e_alu);
    check({tag, ".dest"},      32'(dest_out),  32'(e_alu[3:0]));
  endtask

  task automatic v(input logic fz, input logic fl, input logic iv, input logic ordy,
                   input logic [2:0] c, input logic [31:0] a,
                   input logic e_ov, input logic e_ir, input logic [2:0] e_c, input logic [31:0] e_a);
    vec_t t;
    t.fz = fz; t.fl = fl; t.iv = iv; t.ordy = ordy; t.ctrl = c; t.alu = a;
    t.e_ov = e_ov; t.e_ir = e_ir; t.e_ctrl = e_c; t.e_alu = e_a;
    vq.push_back(t);
  endtask

  initial begin
    // Outputs are sampled within the cycle, before the edge that consumes the inputs.
    //fz fl iv or ctrl    alu          ov ir e_ctrl  e_alu
    v(0, 0, 1, 1, 3'b100, 32'h11,      0, 1, 3'b000, 32'h00);
    v(0, 0, 1, 1, 3'b010, 32'h22,      1, 1, 3'b100, 32'h11);
    v(0, 0, 1, 1, 3'b001, 32'h33,      1, 1, 3'b010, 32'h22);
    v(0, 0, 0, 1, 3'b000, 32'h00,      1, 1, 3'b001, 32'h33);
    v(0, 0, 0, 1, 3'b000, 32'h00,      0, 1, 3'b000, 32'h33);
    v(0, 0, 1, 0, 3'b110, 32'h44,      0, 1, 3'b000, 32'h33);
    v(0, 0, 1, 0, 3'b011, 32'h55,      1, 1, 3'b110, 32'h44);
    v(0, 0, 1, 0, 3'b111, 32'h66,      1, 0, 3'b110, 32'h44);
    v(0, 0, 0, 1, 3'b000, 32'h00,      1, 0, 3'b110, 32'h44);
    v(0, 0, 0, 1, 3'b000, 32'h00,      1, 1, 3'b011, 32'h55);
    v(0, 0, 0, 1, 3'b000, 32'h00,      0, 1, 3'b000, 32'h55);
    v(0, 0, 1, 0, 3'b111, 32'h77,      0, 1, 3'b000, 32'h55);
    v(0, 0, 1, 0, 3'b101, 32'h88,      1, 1, 3'b111, 32'h77);
    v(0, 1, 1, 0, 3'b110, 32'h99,      1, 0, 3'b111, 32'h77);
    v(0, 0, 0, 1, 3'b000, 32'h00,      0, 1, 3'b000, 32'h77);
    v(0, 0, 0, 1, 3'b000, 32'h00,      0, 1, 3'b000, 32'h77);
    v(0, 0, 1, 0, 3'b101, 32'hAA,      0, 1, 3'b000, 32'h77);
    for (int k = 0; k < 4; k++)
      v(1, 0, 1, 1, 3'b010, 32'hBB,    0, 0, 3'b000, 32'hAA);
    v(0, 0, 0, 1, 3'b000, 32'h00,      1, 1, 3'b101, 32'hAA);
    v(0, 0, 0, 1, 3'b000, 32'h00,      0, 1, 3'b000, 32'hAA);
    v(0, 0, 1, 0, 3'b011, 32'hCC,      0, 1, 3'b000, 32'hAA);
    v(1, 1, 1, 1, 3'b111, 32'hDD,      0, 0, 3'b000, 32'hCC);
    v(0, 0, 0, 1, 3'b000, 32'h00,      0, 1, 3'b000, 32'hCC);

    rst = 1'b1;
    drive(0, 0, 0, 0, 3'b000, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_out("reset", 1'b0, 1'b1, 3'b000, 32'h0);

    // Fill to FULL, then reset asynchronously between edges.
    @(posedge clk); #1 drive(0, 0, 1, 0, 3'b111, 32'hDEAD0001);
    @(posedge clk); #1 drive(0, 0, 1, 0, 3'b011, 32'hDEAD0002);
    @(posedge clk); #1 drive(0, 0, 0, 0, 3'b000, 32'h0);
    @(negedge clk);
    check_out("full", 1'b1, 1'b0, 3'b111, 32'hDEAD0001);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    check_out("rst_mid", 1'b0, 1'b1, 3'b000, 32'h0);
    @(posedge clk); #1 drive(0, 0, 0, 1, 3'b000, 32'h0);
    @(negedge clk);
    check_out("rst_after", 1'b0, 1'b1, 3'b000, 32'h0);

    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clk); #1;
      drive(vq[i].fz, vq[i].fl, vq[i].iv, vq[i].ordy, vq[i].ctrl, vq[i].alu);
      @(negedge clk);
      check_out($sformatf("vec%0d", i), vq[i].e_ov, vq[i].e_ir, vq[i].e_ctrl, vq[i].e_alu);
    end

`ifdef PIPE_STALL_CNT_EN
    @(posedge clk); #1 rst = 1'b1; drive(0, 0, 0, 0, 3'b000, 32'h0);
    #2 rst = 1'b0;
    check("stall_rst0", 32'(stall_cnt), 32'h0);
    @(posedge clk); #1 drive(0, 0, 1, 0, 3'b100, 32'h1234);
    @(posedge clk); #1 drive(0, 0, 0, 0, 3'b000, 32'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_5", 32'(stall_cnt), 32'h5);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("stall_sat", 32'(stall_cnt), 32'hF);
    @(posedge clk); #1 drive(0, 1, 0, 0, 3'b000, 32'h0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 3'b000, 32'h0);
    @(negedge clk);
    check("stall_flush", 32'(stall_cnt), 32'hF);
    check("stall_flush_ov", 32'(out_valid), 32'h0);
    rst = 1'b1;
    #2 rst = 1'b0;
    check("stall_rst", 32'(stall_cnt), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
